cache_level_ctrl: RTL and testbench



---
 rtl/cache_pkg.sv | 44 ++++
 rtl/cache_level_ctrl_if.sv | 28 ++
 rtl/cache_repl.sv | 73 +++++++
 rtl/cache_level_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_cache_level_ctrl.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared constants, policy/state types and geometry helpers for one cache level.
// Geometry helpers derive the address-split widths from the instance parameters.
package cache_pkg;

    localparam logic [7:0] OP_READ  = 8'h72;
    localparam logic [7:0] OP_WRITE = 8'h77;

    typedef enum logic {
        WP_WT = 1'b0,
        WP_WB = 1'b1
    } write_pol_e;

    typedef enum logic {
        RP_FIFO = 1'b0,
        RP_LRU  = 1'b1
    } repl_pol_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WBACK,
        ST_FILL,
        ST_WTHRU,
        ST_RESP
    } state_e;

    function automatic int off_bits(input int block_bytes);
        return $clog2(block_bytes);
    endfunction

    function automatic int idx_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int num_sets, input int block_bytes);
        return addr_w - $clog2(num_sets) - $clog2(block_bytes);
    endfunction

    // A direct-mapped level still needs a 1-bit way select to keep port widths legal.
    function automatic int way_bits(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

endpackage

// File: rtl/cache_level_ctrl_if.sv
// Request/response and next-level handshake bundle for one cache level.
// The controller uses the slave view; the requester and next-level model use master.
interface cache_level_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              write_policy;
    logic              replace_policy;
    logic              req_valid;
    logic              req_ready;
    logic [7:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_hit;
    logic              nl_valid;
    logic              nl_ready;
    logic              nl_write;
    logic [ADDR_W-1:0] nl_addr;

    modport slave (
        input  write_policy, replace_policy, req_valid, req_op, req_addr, nl_ready,
        output req_ready, resp_valid, resp_hit, nl_valid, nl_write, nl_addr
    );

    modport master (
        output write_policy, replace_policy, req_valid, req_op, req_addr, nl_ready,
        input  req_ready, resp_valid, resp_hit, nl_valid, nl_write, nl_addr
    );
endinterface

// File: rtl/cache_repl.sv
// Replacement state per set: LRU age permutation and a FIFO install pointer.
// o_victim is the policy choice only; invalid-way preference is applied by the caller.
module cache_repl
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 64,
    parameter int ASSOC    = 4,
    localparam int IDX_W   = idx_bits(NUM_SETS),
    localparam int WAY_W   = way_bits(ASSOC)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] i_set,
    input  logic             i_touch,
    input  logic [WAY_W-1:0] i_touch_way,
    input  logic             i_install,
    input  repl_pol_e        i_policy,
    output logic [WAY_W-1:0] o_victim
);

    logic [WAY_W-1:0] r_fifo_ptr [NUM_SETS];
    logic [WAY_W-1:0] w_lru_way;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < NUM_SETS; s++) r_fifo_ptr[s] <= '0;
        end else if (i_install) begin
            r_fifo_ptr[i_set] <= (r_fifo_ptr[i_set] == WAY_W'(ASSOC - 1)) ? '0
                                                                          : r_fifo_ptr[i_set] + 1'b1;
        end
    end

    generate
        if (ASSOC > 1) begin : g_lru
            logic [WAY_W-1:0] r_age [NUM_SETS][ASSOC];
            logic [WAY_W-1:0] w_old_age;
            logic [ASSOC-1:0] w_oldest;

            assign w_old_age = r_age[i_set][i_touch_way];

            // Ages restart as the identity permutation so the update rule keeps them a permutation.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int s = 0; s < NUM_SETS; s++)
                        for (int w = 0; w < ASSOC; w++)
                            r_age[s][w] <= WAY_W'(w);
                end else if (i_touch) begin
                    for (int w = 0; w < ASSOC; w++) begin
                        if (WAY_W'(w) == i_touch_way)
                            r_age[i_set][w] <= '0;
                        else if (r_age[i_set][w] < w_old_age)
                            r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
                    end
                end
            end

            for (genvar gi = 0; gi < ASSOC; gi++) begin : g_old
                assign w_oldest[gi] = (r_age[i_set][gi] == WAY_W'(ASSOC - 1));
            end

            always_comb begin
                w_lru_way = '0;
                for (int w = ASSOC - 1; w >= 0; w--)
                    if (w_oldest[w]) w_lru_way = WAY_W'(w);
            end
        end else begin : g_no_lru
            assign w_lru_way = '0;
        end
    endgenerate

    assign o_victim = (i_policy == RP_LRU) ? w_lru_way : r_fifo_ptr[i_set];

endmodule

// File: rtl/cache_level_ctrl.sv
// One set-associative cache level: lookup FSM, next-level writeback/fill/write-through
// port and saturating statistics counters.
module cache_level_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_SETS    = 64,
    parameter int ASSOC       = 4,
    parameter int ADDR_W      = 32,
    parameter int BLOCK_BYTES = 32,
    parameter int CNT_W       = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    cache_level_ctrl_if.slave bus,
    output logic [CNT_W-1:0] reads,
    output logic [CNT_W-1:0] writes,
    output logic [CNT_W-1:0] hits,
    output logic [CNT_W-1:0] misses,
    output logic [CNT_W-1:0] writebacks
);

    localparam int OFF_W = off_bits(BLOCK_BYTES);
    localparam int IDX_W = idx_bits(NUM_SETS);
    localparam int TAG_W = tag_bits(ADDR_W, NUM_SETS, BLOCK_BYTES);
    localparam int WAY_W = way_bits(ASSOC);
    localparam int BLK_W = ADDR_W - OFF_W;

    state_e           r_state;
    logic [7:0]       r_op;
    logic [BLK_W-1:0] r_blk;
    write_pol_e       r_wpol;
    repl_pol_e        r_rpol;
    logic [WAY_W-1:0] r_victim;
    logic             r_req_ready, r_resp_valid, r_resp_hit;
    logic             r_nl_valid, r_nl_write;
    logic [ADDR_W-1:0] r_nl_addr;

    logic [TAG_W-1:0] r_tag   [NUM_SETS][ASSOC];
    logic [ASSOC-1:0] r_valid [NUM_SETS];
    logic [ASSOC-1:0] r_dirty [NUM_SETS];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [ADDR_W-1:0] w_req_addr, w_victim_addr;
    logic [ASSOC-1:0]  w_match;
    logic              w_hit, w_has_free, w_is_rd, w_is_wr, w_op_ok;
    logic              w_lookup, w_install, w_touch, w_victim_dirty;
    logic [WAY_W-1:0]  w_hit_way, w_free_way, w_repl_way, w_victim, w_touch_way;
    logic [4:0]        w_cnt_inc;
    logic [4:0][CNT_W-1:0] w_cnt;

    assign w_idx      = r_blk[IDX_W-1:0];
    assign w_tag      = r_blk[BLK_W-1:IDX_W];
    assign w_req_addr = {r_blk, {OFF_W{1'b0}}};
    assign w_is_rd    = (r_op == OP_READ);
    assign w_is_wr    = (r_op == OP_WRITE);
    assign w_op_ok    = w_is_rd || w_is_wr;
    assign w_lookup   = (r_state == ST_LOOKUP);
    assign w_install  = (r_state == ST_FILL) && bus.nl_ready;

    generate
        for (genvar gi = 0; gi < ASSOC; gi++) begin : g_cmp
            assign w_match[gi] = r_valid[w_idx][gi] && (r_tag[w_idx][gi] == w_tag);
        end
    endgenerate

    assign w_hit      = |w_match;
    assign w_has_free = ~&r_valid[w_idx];

    always_comb begin
        w_hit_way  = '0;
        w_free_way = '0;
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (w_match[w])         w_hit_way  = WAY_W'(w);
            if (!r_valid[w_idx][w]) w_free_way = WAY_W'(w);
        end
    end

    assign w_victim       = w_has_free ? w_free_way : w_repl_way;
    assign w_victim_dirty = r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim];
    assign w_victim_addr  = {r_tag[w_idx][w_victim], w_idx, {OFF_W{1'b0}}};
    assign w_touch        = (w_lookup && w_op_ok && w_hit) || w_install;
    assign w_touch_way    = w_install ? r_victim : w_hit_way;

    cache_repl #(
        .NUM_SETS (NUM_SETS),
        .ASSOC    (ASSOC)
    ) u_repl (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_set       (w_idx),
        .i_touch     (w_touch),
        .i_touch_way (w_touch_way),
        .i_install   (w_install),
        .i_policy    (r_rpol),
        .o_victim    (w_repl_way)
    );

    always_ff @(posedge clk) begin
        if (w_install) r_tag[w_idx][r_victim] <= w_tag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_blk        <= '0;
            r_wpol       <= WP_WT;
            r_rpol       <= RP_FIFO;
            r_victim     <= '0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_nl_valid   <= 1'b0;
            r_nl_write   <= 1'b0;
            r_nl_addr    <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_op        <= bus.req_op;
                        r_blk       <= bus.req_addr[ADDR_W-1:OFF_W];
                        r_wpol      <= write_pol_e'(bus.write_policy);
                        r_rpol      <= repl_pol_e'(bus.replace_policy);
                        r_req_ready <= 1'b0;
                        r_state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_resp_hit <= w_op_ok && w_hit;
                    r_victim   <= w_victim;
                    if (!w_op_ok || (w_hit && !(w_is_wr && r_wpol == WP_WT))) begin
                        if (w_op_ok && w_is_wr) r_dirty[w_idx][w_hit_way] <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else if (w_is_wr && r_wpol == WP_WT) begin
                        // Write-through: forward the write, never allocate on a miss.
                        r_nl_valid <= 1'b1;
                        r_nl_write <= 1'b1;
                        r_nl_addr  <= w_req_addr;
                        r_state    <= ST_WTHRU;
                    end else if (w_victim_dirty) begin
                        r_nl_valid <= 1'b1;
                        r_nl_write <= 1'b1;
                        r_nl_addr  <= w_victim_addr;
                        r_state    <= ST_WBACK;
                    end else begin
                        r_nl_valid <= 1'b1;
                        r_nl_write <= 1'b0;
                        r_nl_addr  <= w_req_addr;
                        r_state    <= ST_FILL;
                    end
                end
                ST_WBACK: begin
                    if (bus.nl_ready) begin
                        r_nl_write <= 1'b0;
                        r_nl_addr  <= w_req_addr;
                        r_state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (bus.nl_ready) begin
                        r_nl_valid                <= 1'b0;
                        r_valid[w_idx][r_victim]  <= 1'b1;
                        r_dirty[w_idx][r_victim]  <= w_is_wr;
                        r_resp_valid              <= 1'b1;
                        r_state                   <= ST_RESP;
                    end
                end
                ST_WTHRU: begin
                    if (bus.nl_ready) begin
                        r_nl_valid   <= 1'b0;
                        r_nl_write   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_cnt_inc[0] = w_lookup && w_is_rd;
    assign w_cnt_inc[1] = w_lookup && w_is_wr;
    assign w_cnt_inc[2] = w_lookup && w_op_ok && w_hit;
    assign w_cnt_inc[3] = w_lookup && w_op_ok && !w_hit;
    assign w_cnt_inc[4] = (r_state == ST_WBACK) && bus.nl_ready;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    r_cnt <= '0;
                else if (w_cnt_inc[gi] && (r_cnt != {CNT_W{1'b1}}))
                    r_cnt <= r_cnt + 1'b1;
            end
            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign reads          = w_cnt[0];
    assign writes         = w_cnt[1];
    assign hits           = w_cnt[2];
    assign misses         = w_cnt[3];
    assign writebacks     = w_cnt[4];
    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_hit   = r_resp_hit;
    assign bus.nl_valid   = r_nl_valid;
    assign bus.nl_write   = r_nl_write;
    assign bus.nl_addr    = r_nl_addr;

endmodule

// File: tb/tb_cache_level_ctrl.sv
// Bench for cache_level_ctrl (4 sets, 2 ways, 16-byte blocks, 4-bit counters):
// directed scenarios plus random traffic against a recency/occupancy model of the cache.
module tb_cache_level_ctrl;
    import cache_pkg::*;

    localparam int NS     = 4;
    localparam int NA     = 2;
    localparam int SATMAX = 15;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] reads, writes, hits, misses, writebacks;

    cache_level_ctrl_if #(.ADDR_W(32)) bus();

    cache_level_ctrl #(
        .NUM_SETS(NS), .ASSOC(NA), .ADDR_W(32), .BLOCK_BYTES(16), .CNT_W(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .reads(reads), .writes(writes), .hits(hits), .misses(misses), .writebacks(writebacks)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int txn_no   = 0;

    logic [32:0] nl_log[$];
    logic [32:0] exp_nl[$];

    always @(posedge clk)
        if (reset_n && bus.nl_valid && bus.nl_ready) nl_log.push_back({bus.nl_write, bus.nl_addr});

    // Model: what is resident, when each block was last used, and how many installs per set.
    bit          m_valid [NS][NA];
    bit          m_dirty [NS][NA];
    logic [25:0] m_tag   [NS][NA];
    int unsigned m_stamp [NS][NA];
    int unsigned m_inst  [NS];
    int unsigned m_time;
    int unsigned m_cnt   [5];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void bump(input int i);
        if (m_cnt[i] < SATMAX) m_cnt[i]++;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_inst[s] = 0;
            for (int w = 0; w < NA; w++) begin
                m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = '0; m_stamp[s][w] = 0;
            end
        end
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_time = 0;
    endtask

    task automatic model_access(input logic [7:0] op, input logic [31:0] addr,
                                input bit wb, input bit lru, output bit hit);
        int          set, way, vic;
        logic [25:0] tag;
        logic [31:0] blk;
        set = int'(addr[5:4]);
        tag = addr[31:6];
        blk = {addr[31:4], 4'h0};
        hit = 0;
        exp_nl.delete();
        if (op != OP_READ && op != OP_WRITE) return;
        bump(op == OP_READ ? 0 : 1);
        way = -1;
        for (int w = 0; w < NA; w++)
            if (m_valid[set][w] && m_tag[set][w] == tag) way = w;
        m_time++;
        if (way >= 0) begin
            hit = 1;
            bump(2);
            m_stamp[set][way] = m_time;
            if (op == OP_WRITE) begin
                if (wb) m_dirty[set][way] = 1;
                else    exp_nl.push_back({1'b1, blk});
            end
        end else begin
            bump(3);
            if (op == OP_WRITE && !wb) begin
                exp_nl.push_back({1'b1, blk});
            end else begin
                vic = -1;
                for (int w = NA - 1; w >= 0; w--) if (!m_valid[set][w]) vic = w;
                if (vic < 0) begin
                    if (lru) begin
                        vic = 0;
                        for (int w = 1; w < NA; w++)
                            if (m_stamp[set][w] < m_stamp[set][vic]) vic = w;
                    end else begin
                        vic = int'(m_inst[set] % NA);
                    end
                end
                if (m_valid[set][vic] && m_dirty[set][vic]) begin
                    exp_nl.push_back({1'b1, m_tag[set][vic], set[1:0], 4'h0});
                    bump(4);
                end
                exp_nl.push_back({1'b0, blk});
                m_valid[set][vic] = 1;
                m_tag[set][vic]   = tag;
                m_dirty[set][vic] = (op == OP_WRITE);
                m_stamp[set][vic] = m_time;
                m_inst[set]++;
            end
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_reads"},      reads,      m_cnt[0]);
        chk({tag, "_writes"},     writes,     m_cnt[1]);
        chk({tag, "_hits"},       hits,       m_cnt[2]);
        chk({tag, "_misses"},     misses,     m_cnt[3]);
        chk({tag, "_writebacks"}, writebacks, m_cnt[4]);
    endtask

    task automatic do_reset();
        bus.req_valid = 0; bus.req_op = 8'h00; bus.req_addr = '0; bus.nl_ready = 1;
        bus.write_policy = 0; bus.replace_policy = 0;
        reset_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  bus.req_ready,  1);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_nl_valid",   bus.nl_valid,   0);
        chk("rst_nl_write",   bus.nl_write,   0);
        chk("rst_nl_addr",    bus.nl_addr,    0);
        model_reset();
        chk_counters("rst");
        reset_n = 1;
    endtask

    // One request with nl_ready held high; a competing request is held on the bus while busy.
    task automatic do_txn(input logic [7:0] op, input logic [31:0] addr, input bit wb, input bit lru);
        bit ehit, seen;
        int lat, nexp;
        model_access(op, addr, wb, lru, ehit);
        nexp = exp_nl.size();
        @(negedge clk);
        nl_log.delete();
        chk("idle_req_ready", bus.req_ready, 1);
        bus.req_valid = 1; bus.req_op = op; bus.req_addr = addr;
        bus.write_policy = wb; bus.replace_policy = lru;
        @(posedge clk);
        #1;
        bus.req_op = OP_WRITE; bus.req_addr = addr ^ 32'h40;
        bus.write_policy = ~wb; bus.replace_policy = ~lru;
        seen = 0; lat = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin seen = 1; lat = k; end
        end
        bus.req_valid = 0;
        chk("resp_seen", seen, 1);
        chk("latency", lat, 2 + nexp);
        chk("resp_hit", bus.resp_hit, ehit);
        chk("nl_count", nl_log.size(), nexp);
        for (int i = 0; i < nexp && i < nl_log.size(); i++) chk("nl_op", nl_log[i], exp_nl[i]);
        @(negedge clk);
        chk("resp_pulse", bus.resp_valid, 0);
        txn_no++;
        $display("txn %0d op=%02h addr=%08h wb=%0d lru=%0d hit=%0d lat=%0d nl_ops=%0d",
                 txn_no, op, addr, wb, lru, bus.resp_hit, lat, nl_log.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  rop;
        logic [31:0] raddr;
        int          r;

        // Reset mid-fill with the next level stalled.
        do_reset();
        bus.nl_ready = 0;
        @(negedge clk);
        bus.req_valid = 1; bus.req_op = OP_READ; bus.req_addr = 32'h0000_0008;
        bus.write_policy = 1; bus.replace_policy = 1;
        @(posedge clk);
        #1 bus.req_valid = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_nl_valid", bus.nl_valid, 1);
            chk("stall_nl_write", bus.nl_write, 0);
            chk("stall_nl_addr",  bus.nl_addr,  32'h0);
            chk("stall_busy",     bus.req_ready, 0);
        end
        chk("stall_reads",  reads,  1);
        chk("stall_misses", misses, 1);
        #1 reset_n = 0;
        #1;
        chk("async_nl_valid",  bus.nl_valid,  0);
        chk("async_req_ready", bus.req_ready, 1);
        chk("async_reads",     reads,         0);
        chk("async_misses",    misses,        0);
        @(negedge clk);
        reset_n = 1; bus.nl_ready = 1;
        model_reset();
        do_txn(OP_READ, 32'h00, 1, 1);
        chk("post_rst_misses", misses, 1);

        // Write-back / LRU: miss then hit on the same block.
        do_reset();
        do_txn(OP_READ, 32'h00, 1, 1);
        do_txn(OP_READ, 32'h00, 1, 1);
        chk("t2_reads", reads, 2);
        chk("t2_hits", hits, 1);
        chk("t2_misses", misses, 1);

        // Write-back / LRU eviction order in set 0.
        do_reset();
        do_txn(OP_WRITE, 32'h00, 1, 1);
        do_txn(OP_READ,  32'h40, 1, 1);
        do_txn(OP_READ,  32'h00, 1, 1);
        chk("lru_third_hit", hits, 1);
        do_txn(OP_READ,  32'h80, 1, 1);
        chk("lru_no_wb_yet", writebacks, 0);
        do_txn(OP_READ,  32'hC0, 1, 1);
        chk("lru_wb_addr", nl_log.size() > 0 ? nl_log[0] : 33'h0, {1'b1, 32'h00});
        chk("lru_writebacks", writebacks, 1);
        chk_counters("lru");

        // Same sequence under FIFO: the dirty first install is the victim.
        do_reset();
        do_txn(OP_WRITE, 32'h00, 1, 0);
        do_txn(OP_READ,  32'h40, 1, 0);
        do_txn(OP_READ,  32'h00, 1, 0);
        do_txn(OP_READ,  32'h80, 1, 0);
        chk("fifo_writebacks", writebacks, 1);
        chk_counters("fifo");

        // Write-through / no-write-allocate.
        do_reset();
        do_txn(OP_WRITE, 32'h10, 0, 1);
        do_txn(OP_READ,  32'h10, 0, 1);
        chk("wt_misses", misses, 2);
        chk("wt_writebacks", writebacks, 0);

        // Counter saturation and no-op requests.
        do_reset();
        for (int i = 0; i < 20; i++) do_txn(OP_READ, 32'h00, 1, 1);
        chk("sat_reads", reads, 15);
        chk("sat_hits", hits, 15);
        chk("sat_misses", misses, 1);
        do_txn(8'h00, 32'h00, 1, 1);
        chk_counters("noop");

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 9)       rop = OP_READ;
            else if (r < 18) rop = OP_WRITE;
            else if (r < 19) rop = 8'h52;
            else             rop = 8'hFF;
            raddr = {26'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            do_txn(rop, raddr, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            if (n % 15 == 14) chk_counters("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
